// File: rtl/adpll_tdc_dec_if.sv
// adpll_tdc_dec_if: bundles the TDC decoder control, sample and result signals.
// Latency: n/a (wires only).
// Backpressure: none; the decoder emits one word per enabled cycle.
// Ports (master = ADPLL side / bench, slave = decoder):
//   en, clr_err, tdc_ripple_count, tdc_phase   master -> slave
//   tdc_word, tdc_valid, bubble_cnt            slave  -> master
interface adpll_tdc_dec_if #(
  parameter int RIPPLE_W = 7,
  parameter int PHASE_W  = 16,
  parameter int WORD_W   = 12
);
  logic                en;
  logic                clr_err;
  logic [RIPPLE_W-1:0] tdc_ripple_count;
  logic [PHASE_W-1:0]  tdc_phase;
  logic [WORD_W-1:0]   tdc_word;
  logic                tdc_valid;
  logic [7:0]          bubble_cnt;

  modport master (
    output en, clr_err, tdc_ripple_count, tdc_phase,
    input  tdc_word, tdc_valid, bubble_cnt
  );

  modport slave (
    input  en, clr_err, tdc_ripple_count, tdc_phase,
    output tdc_word, tdc_valid, bubble_cnt
  );
endinterface

// File: rtl/adpll_tdc_dec.sv
// adpll_tdc_dec: decodes TDC coarse ripple count + thermometer phase into {coarse_ext, fine}.
// Latency: 2 cycles input -> tdc_word; first tdc_valid 2 cycles after en rises.
// Backpressure: none; one word per enabled cycle, tdc_word holds while en is low.
// Ports: clk; rst (async, active-low); bus (slave modport): en, clr_err,
//   tdc_ripple_count, tdc_phase in; tdc_word, tdc_valid, bubble_cnt out.
// Option macro ADPLL_TDC_BUBBLE_FIX_EN: fine = popcount of phase (bubble tolerant);
//   otherwise fine = length of the ones run starting at bit 0.
module adpll_tdc_dec #(
  parameter int RIPPLE_W = 7,
  parameter int PHASE_W  = 16,
  parameter int WORD_W   = 12
) (
  input  logic           clk,
  input  logic           rst,
  adpll_tdc_dec_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t              state_q;
  logic                tdc_valid_q;
  logic [RIPPLE_W-1:0] ripple_s1_q;
  logic [PHASE_W-1:0]  phase_s1_q;
  logic [RIPPLE_W-1:0] prev_ripple_q;
  logic                msb_q, msb_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [7:0]          bubble_cnt_q, bubble_cnt_d;

  logic                s2_act, wrap, bubble, bubble_ev;
  logic [PHASE_W-1:0]  phase_inc;
  logic [3:0]          fine;
  int                  fine_cnt;

`ifdef ADPLL_TDC_BUBBLE_FIX_EN
  function automatic int phase_count(input logic [PHASE_W-1:0] p);
    int n;
    n = 0;
    for (int i = 0; i < PHASE_W; i++) begin
      if (p[i]) n++;
    end
    return n;
  endfunction
`else
  function automatic int phase_count(input logic [PHASE_W-1:0] p);
    int   n;
    logic stop;
    n    = 0;
    stop = 1'b0;
    for (int i = 0; i < PHASE_W; i++) begin
      if (!p[i]) stop = 1'b1;
      else if (!stop) n++;
    end
    return n;
  endfunction
`endif

  always_comb begin
    fine_cnt  = phase_count(phase_s1_q);
    fine      = (fine_cnt > 15) ? 4'hF : 4'(fine_cnt);
    // A clean thermometer is 2^k-1, so p & (p+1) is zero exactly then
    // (all-ones wraps to zero and all-zeros stays zero).
    phase_inc = phase_s1_q + PHASE_W'(1);
    bubble    = |(phase_s1_q & phase_inc);
    // S2 only advances while enabled and past IDLE; this also freezes the
    // word and wrap history the cycle en drops.
    s2_act    = bus.en && (state_q != IDLE);
    wrap      = (state_q == RUN) && (ripple_s1_q < prev_ripple_q);
    // FILL restarts the wrap history so a stale ripple cannot fake a wrap.
    msb_d     = (state_q == FILL) ? 1'b0 : (msb_q ^ wrap);
    word_d    = WORD_W'({msb_d, 7'(ripple_s1_q), fine});
    bubble_ev = s2_act && bubble;
    if (bus.clr_err) begin
      bubble_cnt_d = bubble_ev ? 8'd1 : 8'd0;
    end else if (bubble_ev && (bubble_cnt_q != 8'hFF)) begin
      bubble_cnt_d = bubble_cnt_q + 8'd1;
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // S1: raw capture of the analog TDC outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ripple_s1_q <= '0;
      phase_s1_q  <= '0;
    end else begin
      ripple_s1_q <= bus.tdc_ripple_count;
      phase_s1_q  <= bus.tdc_phase;
    end
  end

  // Control FSM; tdc_valid is registered alongside the state it reflects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tdc_valid_q <= 1'b0;
    end else if (!bus.en) begin
      state_q     <= IDLE;
      tdc_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= FILL;
          tdc_valid_q <= 1'b0;
        end
        FILL, RUN: begin
          state_q     <= RUN;
          tdc_valid_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          tdc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // S2: decode result, wrap history and bubble counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msb_q         <= 1'b0;
      prev_ripple_q <= '0;
      word_q        <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      if (s2_act) begin
        msb_q         <= msb_d;
        prev_ripple_q <= ripple_s1_q;
        word_q        <= word_d;
      end
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.tdc_word   = word_q;
  assign bus.tdc_valid  = tdc_valid_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_adpll_tdc_dec.sv
// tb_adpll_tdc_dec: table-driven bench with an output scoreboard for adpll_tdc_dec.
// Latency: checks the 2-cycle pipeline and 2-cycle valid start-up.
// Backpressure: n/a; inputs are driven on the falling edge, outputs sampled there too.
module tb_adpll_tdc_dec;

`ifdef ADPLL_TDC_BUBBLE_FIX_EN
  localparam bit FIX = 1'b1;
`else
  localparam bit FIX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adpll_tdc_dec_if #(.RIPPLE_W(7), .PHASE_W(16), .WORD_W(12)) bus ();

  adpll_tdc_dec #(.RIPPLE_W(7), .PHASE_W(16), .WORD_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [11:0] w;
    logic [7:0]  bc;
  } exp_t;

  typedef struct {
    logic        en;
    logic        clr;
    logic [6:0]  rip;
    logic [15:0] ph;
    logic [11:0] ew;
    logic [7:0]  ebc;
    int          chk;   // tdc_valid expected at this step's sample: 0, 1, or 2 = don't care
  } vec_t;

  exp_t sb[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic en_prev = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: sample outputs / pop scoreboard, then drive the next inputs.
  task automatic cyc(input logic en_v, input logic clr_v, input logic [6:0] rip,
                     input logic [15:0] ph, input logic [11:0] ew, input logic [7:0] ebc,
                     input int chk);
    exp_t e;
    @(negedge clk);
    if (chk != 2) check("tdc_valid", 32'(bus.tdc_valid), 32'(chk));
    if (bus.tdc_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got word %0h with no expected entry", bus.tdc_word);
      end else begin
        e = sb.pop_front();
        check("tdc_word", 32'(bus.tdc_word), 32'(e.w));
        check("bubble_cnt", 32'(bus.bubble_cnt), 32'(e.bc));
      end
    end
    // The sample driven last cycle never reaches S2 once en drops.
    if (!en_v && en_prev && sb.size() > 0) void'(sb.pop_back());
    bus.en               = en_v;
    bus.clr_err          = clr_v;
    bus.tdc_ripple_count = rip;
    bus.tdc_phase        = ph;
    if (en_v) sb.push_back('{w: ew, bc: ebc});
    en_prev = en_v;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst                  = 1'b0;
    bus.en               = 1'b0;
    bus.clr_err          = 1'b0;
    bus.tdc_ripple_count = '0;
    bus.tdc_phase        = '0;

    tbl[0]  = '{1'b1, 1'b0, 7'd5,   16'h00FF, 12'h058, 8'd0, 0};
    tbl[1]  = '{1'b1, 1'b0, 7'd5,   16'h00FF, 12'h058, 8'd0, 0};
    tbl[2]  = '{1'b1, 1'b0, 7'd5,   16'h00FF, 12'h058, 8'd0, 1};
    tbl[3]  = '{1'b1, 1'b0, 7'd126, 16'h0000, 12'h7E0, 8'd0, 1};
    tbl[4]  = '{1'b1, 1'b0, 7'd127, 16'h0000, 12'h7F0, 8'd0, 1};
    tbl[5]  = '{1'b1, 1'b0, 7'd0,   16'h0000, 12'h800, 8'd0, 1};
    tbl[6]  = '{1'b1, 1'b0, 7'd1,   16'h0000, 12'h810, 8'd0, 1};
    tbl[7]  = '{1'b1, 1'b0, 7'd1,   16'h00F7, FIX ? 12'h817 : 12'h813, 8'd1, 1};
    tbl[8]  = '{1'b1, 1'b0, 7'd1,   16'h0000, 12'h810, 8'd1, 1};
    tbl[9]  = '{1'b1, 1'b0, 7'd2,   16'hFFFF, 12'h82F, 8'd1, 1};
    tbl[10] = '{1'b1, 1'b0, 7'd2,   16'h0001, 12'h821, 8'd1, 1};
    tbl[11] = '{1'b1, 1'b0, 7'd2,   16'h0002, FIX ? 12'h821 : 12'h820, 8'd2, 1};
    tbl[12] = '{1'b1, 1'b0, 7'd3,   16'h8000, FIX ? 12'h831 : 12'h830, 8'd3, 1};
    tbl[13] = '{1'b1, 1'b0, 7'd3,   16'h7FFF, 12'h83F, 8'd3, 1};
    // clr_err lands on the S2 cycle of the previous row.
    tbl[14] = '{1'b1, 1'b0, 7'd3,   16'h0005, FIX ? 12'h832 : 12'h831, 8'd1, 1};
    tbl[15] = '{1'b1, 1'b1, 7'd3,   16'h0000, 12'h830, 8'd0, 1};
    tbl[16] = '{1'b1, 1'b1, 7'd3,   16'h0000, 12'h830, 8'd0, 1};
    tbl[17] = '{1'b1, 1'b0, 7'd3,   16'h0000, 12'h830, 8'd0, 1};

    repeat (2) @(negedge clk);
    check("rst_word", 32'(bus.tdc_word), 32'h0);
    check("rst_valid", 32'(bus.tdc_valid), 32'h0);
    check("rst_bubble_cnt", 32'(bus.bubble_cnt), 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++)
      cyc(tbl[i].en, tbl[i].clr, tbl[i].rip, tbl[i].ph, tbl[i].ew, tbl[i].ebc, tbl[i].chk);

    // Bubble counter saturation.
    for (int k = 1; k <= 260; k++)
      cyc(1'b1, 1'b0, 7'd3, 16'h0002, FIX ? 12'h831 : 12'h830,
          (k > 255) ? 8'd255 : 8'(k), 1);

    // en low for 5 cycles, then re-enable at a lower ripple value.
    cyc(1'b1, 1'b0, 7'd10, 16'h0000, 12'h8A0, 8'd255, 1);
    cyc(1'b1, 1'b0, 7'd10, 16'h0000, 12'h8A0, 8'd255, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 7'd3, 16'h0000, 12'h000, 8'd0, (k == 0) ? 1 : 0);
      if (k > 0) check("idle_word_hold", 32'(bus.tdc_word), 32'h8A0);
    end
    cyc(1'b1, 1'b0, 7'd3, 16'h0000, 12'h030, 8'd255, 0);
    cyc(1'b1, 1'b0, 7'd3, 16'h0000, 12'h030, 8'd255, 0);
    cyc(1'b1, 1'b0, 7'd4, 16'h0000, 12'h040, 8'd255, 1);
    cyc(1'b1, 1'b0, 7'd4, 16'h0000, 12'h040, 8'd255, 1);

    // Reset in RUN: outputs clear immediately, restart goes through FILL.
    #2;
    rst = 1'b0;
    #1;
    check("midrst_word", 32'(bus.tdc_word), 32'h0);
    check("midrst_valid", 32'(bus.tdc_valid), 32'h0);
    check("midrst_bubble_cnt", 32'(bus.bubble_cnt), 32'h0);
    sb.delete();
    bus.en               = 1'b1;
    bus.clr_err          = 1'b0;
    bus.tdc_ripple_count = 7'd5;
    bus.tdc_phase        = 16'h00FF;
    en_prev              = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{w: 12'h058, bc: 8'd0});
    cyc(1'b1, 1'b0, 7'd5, 16'h00FF, 12'h058, 8'd0, 0);
    cyc(1'b1, 1'b0, 7'd5, 16'h00FF, 12'h058, 8'd0, 1);
    cyc(1'b1, 1'b0, 7'd5, 16'h00FF, 12'h058, 8'd0, 1);

    // Drain.
    cyc(1'b0, 1'b0, 7'd0, 16'h0000, 12'h000, 8'd0, 1);
    cyc(1'b0, 1'b0, 7'd0, 16'h0000, 12'h000, 8'd0, 0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adpll_tdc_dec.md
ADPLL_TDC_DEC -- requirements
Module: adpll_tdc_dec

Interface
REQ-001 SHALL have parameter RIPPLE_W, default 7, width of the TDC ripple counter.
REQ-002 SHALL have parameter PHASE_W, default 16, width of the TDC thermometer phase bus.
REQ-003 SHALL have parameter WORD_W, default 12, width of the decoded TDC word.
REQ-004 SHALL have port clk  input  1  sole clock; every register updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port en  input  1  decoder enable from the ADPLL control block.
REQ-007 SHALL have port clr_err  input  1  one-cycle pulse that clears bubble_cnt.
REQ-008 SHALL have port tdc_ripple_count  input  RIPPLE_W  coarse ripple count from the analog TDC.
REQ-009 SHALL have port tdc_phase  input  PHASE_W  thermometer fine phase from the analog TDC.
REQ-010 SHALL have port tdc_word  output  WORD_W  decoded phase word sent to the ADPLL loop.
REQ-011 SHALL have port tdc_valid  output  1  high when tdc_word holds a fresh sample.
REQ-012 SHALL have port bubble_cnt  output  8  saturating count of thermometer bubble events.

Function
REQ-013 SHALL implement a 2-stage pipeline: S1 registers the raw inputs, S2 decodes them and registers the outputs; an input sampled at edge N appears on tdc_word after edge N+2.
REQ-014 SHALL compute fine (4 bits) in S2 from the S1 phase; a value above 15 SHALL saturate to 15.
REQ-015 SHALL extend the coarse count to 8 bits (coarse_ext): when the S1 ripple value is lower than the previous S1 ripple value, bit 7 of coarse_ext SHALL toggle; bits 6:0 SHALL equal the ripple value.
REQ-016 SHALL drive tdc_word = {coarse_ext, fine}, modulo 2^WORD_W, so it wraps from 12'hFFF to 12'h000 naturally.
REQ-017 SHALL treat any phase vector whose ones are not contiguous from bit 0 as a bubble; 16'h0000 and 16'hFFFF SHALL NOT be bubbles.
REQ-018 SHALL increment bubble_cnt by 1 on each S2 bubble, saturating at 255.
REQ-019 SHALL, when clr_err and a bubble occur in the same cycle, set bubble_cnt to 1; clr_err alone SHALL set it to 0.
REQ-020 SHALL use a 3-state control FSM: IDLE (en=0), FILL (first cycle after en rises), RUN.
REQ-021 SHALL have the FSM go IDLE->FILL when en=1, FILL->RUN, and any state->IDLE when en=0.
REQ-022 SHALL hold tdc_valid at 1 only in RUN, so the first valid word appears 2 cycles after en rises.
REQ-023 SHALL hold tdc_word at its last value and keep the wrap history unchanged while in IDLE.
REQ-024 SHALL, on entering FILL, clear coarse_ext bit 7 and load the previous-ripple register from S1 so that no false wrap occurs.
REQ-025 SHALL count bubbles only in FILL or RUN.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear tdc_word, tdc_valid, bubble_cnt, all pipeline registers and the wrap history to 0, and force the FSM to IDLE.
REQ-027 SHALL, after rst is released mid-operation with en=1, restart through FILL, so that tdc_valid goes high no earlier than 2 edges after release.

Configuration
REQ-028 SHALL support the macro ADPLL_TDC_BUBBLE_FIX_EN.
REQ-029 SHALL, when ADPLL_TDC_BUBBLE_FIX_EN is defined, compute fine as the popcount of the phase vector, which makes it bubble-tolerant.
REQ-030 SHALL, when ADPLL_TDC_BUBBLE_FIX_EN is undefined, compute fine as the number of contiguous ones starting at bit 0.
REQ-031 SHALL detect and count bubbles the same way whether or not ADPLL_TDC_BUBBLE_FIX_EN is defined.

Verification
REQ-032 SHALL cover: en=1, ripple=5, phase=16'h00FF held -> tdc_valid rises 2 cycles after en, tdc_word=12'h058, bubble_cnt=0.
REQ-033 SHALL cover: ripple stepping 126, 127, 0, 1 with phase=0 -> tdc_word 12'h7E0, 12'h7F0, 12'h800, 12'h810.
REQ-034 SHALL cover: phase=16'h00F7 for 1 cycle -> fine=7 with the macro or 3 without it, and bubble_cnt 0->1.
REQ-035 SHALL cover: phase=16'hFFFF -> fine=15 (saturated), no bubble; then clr_err together with a bubble -> bubble_cnt=1.
REQ-036 SHALL cover: rst pulled low while in RUN -> all outputs 0 at once; after release with en=1 -> tdc_valid=0 for 2 cycles, then 1.
REQ-037 SHALL cover: en dropped for 5 cycles, then ripple 10->3 -> tdc_valid=0 and tdc_word held during IDLE, and no bit-7 toggle after re-enable.
